// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hold bus encoding,
// control FSM state encoding and the hold merge helper.
package pipe_ctrl_pkg;

    localparam int HOLD_W = 3;

    localparam logic [HOLD_W-1:0] HOLD_NONE = 3'd0;
    localparam logic [HOLD_W-1:0] HOLD_PC   = 3'd1;
    localparam logic [HOLD_W-1:0] HOLD_IF   = 3'd2;
    localparam logic [HOLD_W-1:0] HOLD_ID   = 3'd3;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_RUN    = 3'd0;
    localparam logic [ST_W-1:0] ST_WAIT   = 3'd1;
    localparam logic [ST_W-1:0] ST_HALT   = 3'd2;
    localparam logic [ST_W-1:0] ST_DRAIN  = 3'd3;
    localparam logic [ST_W-1:0] ST_REBOOT = 3'd4;

    // Higher hold level freezes more stages, so merging is a max.
    function automatic logic [HOLD_W-1:0] hold_max(
        input logic [HOLD_W-1:0] a,
        input logic [HOLD_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Central pipeline control: redirect arbitration, hold merge,
// redirect deferral behind fetch, debug halt and drained reboot.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int BOOT_ADDR_W  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ex_jump_req_i,
    input  logic [BOOT_ADDR_W-1:0] ex_jump_addr_i,
    input  logic                   trap_req_i,
    input  logic [BOOT_ADDR_W-1:0] trap_addr_i,
    input  logic                   ex_hold_req_i,
    input  logic                   lsu_hold_req_i,
    input  logic                   ifu_busy_i,
    input  logic                   dbg_halt_req_i,
    input  logic                   dbg_reboot_req_i,
    input  logic [BOOT_ADDR_W-1:0] boot_addr_i,
    output logic                   jump_flag_o,
    output logic [BOOT_ADDR_W-1:0] jump_addr_o,
    output logic [HOLD_W-1:0]      hold_flag_o,
    output logic                   reboot_o,
    output logic                   flush_o,
    output logic                   halted_o
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);

    logic [ST_W-1:0]        r_state;
    logic [BOOT_ADDR_W-1:0] r_pend_addr;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_halted;

    logic [ST_W-1:0]        w_state_nxt;
    logic [BOOT_ADDR_W-1:0] w_pend_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_jump;
    logic [BOOT_ADDR_W-1:0] w_addr;
    logic [HOLD_W-1:0]      w_hold;
    logic                   w_flush;
    logic                   w_reboot;

    logic                   w_redir;
    logic [BOOT_ADDR_W-1:0] w_tgt;
    logic [HOLD_W-1:0]      w_base_hold;
    logic                   w_rb_go;

    assign w_redir = trap_req_i | ex_jump_req_i;
    assign w_tgt   = trap_req_i ? trap_addr_i : ex_jump_addr_i;

    assign w_base_hold = hold_max(
        (ex_hold_req_i | lsu_hold_req_i) ? HOLD_ID : HOLD_NONE,
        ifu_busy_i ? HOLD_PC : HOLD_NONE);

    assign w_rb_go = dbg_reboot_req_i
                   && (r_state != ST_DRAIN)
                   && (r_state != ST_REBOOT);

    // Next-state and output decode; a reboot request overrides
    // whatever the current state decided this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend_addr;
        w_cnt_nxt   = r_cnt;
        w_jump      = 1'b0;
        w_addr      = '0;
        w_hold      = HOLD_ID;
        w_flush     = 1'b0;
        w_reboot    = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_hold = w_base_hold;
                if (w_redir) begin
                    if (!ifu_busy_i) begin
                        w_jump  = 1'b1;
                        w_addr  = w_tgt;
                        w_flush = 1'b1;
                    end else begin
                        w_pend_nxt  = w_tgt;
                        w_state_nxt = ST_WAIT;
                    end
                end else if (dbg_halt_req_i && !ex_hold_req_i
                             && !lsu_hold_req_i) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_WAIT: begin
                if (!ifu_busy_i) begin
                    w_jump      = 1'b1;
                    w_addr      = r_pend_addr;
                    w_flush     = 1'b1;
                    w_state_nxt = ST_RUN;
                end else if (trap_req_i) begin
                    w_pend_nxt = trap_addr_i;
                end
            end
            ST_HALT: begin
                if (!dbg_halt_req_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!ifu_busy_i && !lsu_hold_req_i) begin
                    w_state_nxt = ST_REBOOT;
                end
            end
            ST_REBOOT: begin
                w_reboot    = 1'b1;
                w_flush     = 1'b1;
                w_addr      = boot_addr_i;
                w_hold      = HOLD_NONE;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        if (w_rb_go) begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = CNT_LOAD;
            w_pend_nxt  = '0;
            w_jump      = 1'b0;
            w_addr      = '0;
            w_flush     = 1'b0;
        end
    end

    // Control state, pending redirect, drain counter, halt status.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_RUN;
            r_pend_addr <= '0;
            r_cnt       <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_addr <= w_pend_nxt;
            r_cnt       <= w_cnt_nxt;
            r_halted    <= (w_state_nxt == ST_HALT);
        end
    end

    // Outputs read as idle for the whole time reset is held.
    assign jump_flag_o = rst_ni & w_jump;
    assign jump_addr_o = rst_ni ? w_addr : '0;
    assign hold_flag_o = rst_ni ? w_hold : HOLD_NONE;
    assign reboot_o    = rst_ni & w_reboot;
    assign flush_o     = rst_ni & w_flush;
    assign halted_o    = r_halted;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random
// traffic, checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int DRAIN = 4;
    localparam logic [31:0] BOOT = 32'h0000_1000;

    logic        clk;
    logic        rst_ni;
    logic        ex_jump_req;
    logic [31:0] ex_jump_addr;
    logic        trap_req;
    logic [31:0] trap_addr;
    logic        ex_hold_req;
    logic        lsu_hold_req;
    logic        ifu_busy;
    logic        dbg_halt_req;
    logic        dbg_reboot_req;
    logic [31:0] boot_addr;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic [2:0]  hold_flag;
    logic        reboot;
    logic        flush;
    logic        halted;

    pipe_ctrl #(
        .DRAIN_CYCLES(DRAIN),
        .BOOT_ADDR_W (32)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .ex_jump_req_i   (ex_jump_req),
        .ex_jump_addr_i  (ex_jump_addr),
        .trap_req_i      (trap_req),
        .trap_addr_i     (trap_addr),
        .ex_hold_req_i   (ex_hold_req),
        .lsu_hold_req_i  (lsu_hold_req),
        .ifu_busy_i      (ifu_busy),
        .dbg_halt_req_i  (dbg_halt_req),
        .dbg_reboot_req_i(dbg_reboot_req),
        .boot_addr_i     (boot_addr),
        .jump_flag_o     (jump_flag),
        .jump_addr_o     (jump_addr),
        .hold_flag_o     (hold_flag),
        .reboot_o        (reboot),
        .flush_o         (flush),
        .halted_o        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        jf;
        logic [31:0] ja;
        logic [2:0]  hold;
        logic        rb;
        logic        fl;
        logic        hl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_cyc    = 0;

    // Behavioural model: what mode the control is in, and what it owes.
    localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;
    localparam int M_DRAIN = 3, M_REBOOT = 4;
    int          m_mode;
    logic [31:0] m_pend;
    int          m_elapsed;
    bit          m_halted;

    task automatic model_reset();
        m_mode    = M_RUN;
        m_pend    = '0;
        m_elapsed = 0;
        m_halted  = 1'b0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit   rb_now;
        e = '0;
        if (!rst_ni) return e;
        rb_now = dbg_reboot_req && m_mode != M_DRAIN && m_mode != M_REBOOT;
        e.hold = 3;
        if (m_mode == M_RUN) begin
            if (ex_hold_req || lsu_hold_req) e.hold = 3;
            else if (ifu_busy)               e.hold = 1;
            else                             e.hold = 0;
            if (!rb_now && (trap_req || ex_jump_req) && !ifu_busy) begin
                e.jf = 1;
                e.fl = 1;
                e.ja = trap_req ? trap_addr : ex_jump_addr;
            end
        end else if (m_mode == M_WAIT) begin
            if (!rb_now && !ifu_busy) begin
                e.jf = 1;
                e.fl = 1;
                e.ja = m_pend;
            end
        end else if (m_mode == M_REBOOT) begin
            e.rb   = 1;
            e.fl   = 1;
            e.ja   = boot_addr;
            e.hold = 0;
        end
        e.hl = m_halted;
        return e;
    endfunction

    task automatic model_step();
        bit rb_now;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        rb_now = dbg_reboot_req && m_mode != M_DRAIN && m_mode != M_REBOOT;
        if (rb_now) begin
            m_mode    = M_DRAIN;
            m_elapsed = 0;
            m_pend    = '0;
        end else begin
            case (m_mode)
                M_RUN: begin
                    if (trap_req || ex_jump_req) begin
                        if (ifu_busy) begin
                            m_pend = trap_req ? trap_addr : ex_jump_addr;
                            m_mode = M_WAIT;
                        end
                    end else if (dbg_halt_req && !ex_hold_req && !lsu_hold_req)
                        m_mode = M_HALT;
                end
                M_WAIT: begin
                    if (!ifu_busy)     m_mode = M_RUN;
                    else if (trap_req) m_pend = trap_addr;
                end
                M_HALT: if (!dbg_halt_req) m_mode = M_RUN;
                M_DRAIN: begin
                    if (m_elapsed >= DRAIN && !ifu_busy && !lsu_hold_req)
                        m_mode = M_REBOOT;
                    else
                        m_elapsed++;
                end
                default: m_mode = M_RUN;
            endcase
        end
        m_halted = (m_mode == M_HALT);
    endtask

    // One clock of stimulus: advance model, drive inputs, queue expectation.
    task automatic cyc(
        input bit rst, input bit exj, input logic [31:0] exa,
        input bit tr, input logic [31:0] tra, input bit exh,
        input bit lsu, input bit busy, input bit halt, input bit rb
    );
        @(posedge clk);
        model_step();
        #1;
        rst_ni         = rst;
        ex_jump_req    = exj;
        ex_jump_addr   = exa;
        trap_req       = tr;
        trap_addr      = tra;
        ex_hold_req    = exh;
        lsu_hold_req   = lsu;
        ifu_busy       = busy;
        dbg_halt_req   = halt;
        dbg_reboot_req = rb;
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{jf: jump_flag, ja: jump_addr, hold: hold_flag,
                  rb: reboot, fl: flush, hl: halted};
            n_cyc++;
            n_checks++;
            if (g === e) n_pass++;
            else $display("FAIL outputs cyc%0d: got jf=%0b ja=%h hold=%0d rb=%0b fl=%0b hl=%0b, want jf=%0b ja=%h hold=%0d rb=%0b fl=%0b hl=%0b",
                          n_cyc, g.jf, g.ja, g.hold, g.rb, g.fl, g.hl,
                          e.jf, e.ja, e.hold, e.rb, e.fl, e.hl);
            n_checks++;
            if (!(jump_flag && reboot)) n_pass++;
            else $display("FAIL jump_reboot_excl cyc%0d: got jf=%0b rb=%0b, want not both",
                          n_cyc, jump_flag, reboot);
        end
    end

    initial begin
        bit halt_lvl;
        rst_ni         = 1'b0;
        ex_jump_req    = 1'b0;
        ex_jump_addr   = '0;
        trap_req       = 1'b0;
        trap_addr      = '0;
        ex_hold_req    = 1'b0;
        lsu_hold_req   = 1'b0;
        ifu_busy       = 1'b0;
        dbg_halt_req   = 1'b0;
        dbg_reboot_req = 1'b0;
        boot_addr      = BOOT;
        model_reset();

        // Reset state with noisy inputs still reads idle.
        cyc(0, 1, 32'h44, 1, 32'h88, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Zero-latency EX jump.
        cyc(1, 1, 32'h0000_0100, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Deferred jump, trap overwrites while fetch is busy.
        cyc(1, 1, 32'h0000_0200, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 32'h8000_0000, 0, 0, 1, 0, 0);
        cyc(1, 1, 32'h0000_0300, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Hold merge levels.
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);

        // Debug halt, trap ignored while halted, release.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 32'h8000_0004, 0, 0, 0, 1, 0);
        cyc(1, 1, 32'h0000_0400, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Reboot discards a pending redirect and drains.
        cyc(1, 1, 32'h0000_0500, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(9);

        // Reset in the middle of a deferred redirect.
        cyc(1, 1, 32'h0000_0600, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);

        // Random traffic with occasional reset.
        halt_lvl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) halt_lvl = ~halt_lvl;
            cyc($urandom_range(0, 199) != 0,
                $urandom_range(0, 4) == 0, $urandom(),
                $urandom_range(0, 9) == 0, $urandom(),
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 1) == 1, halt_lvl,
                $urandom_range(0, 24) == 0);
        end
        idle(2);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d entries left, want 0",
                      exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
